freq_meter: RTL



---
 rtl/freq_meter.sv | 113 +++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter measuring the frequency of an asynchronous input
// Counts synchronised rising edges of sig_in over GATE_CYCLES clk cycles; one-shot or continuous.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             overflow
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   sig_s;
  logic                   edge_det;
  logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       freq_cnt_q, freq_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   freq_valid_q, freq_valid_d;

  // s_prev always tracks s, so a level already high when a gate opens is never an edge.
  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign edge_det = sig_s & ~s_prev_q;

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_d        = ovf_q;
    freq_cnt_d   = freq_cnt_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        if (start) state_d = S_GATE;
      end
      S_GATE: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        if (edge_det) begin
          if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + 1'b1;
        end
        // Result is loaded on the last gate cycle so it is visible together with the DONE pulse.
        if (gate_cnt_q == GATE_LAST) begin
          state_d      = S_DONE;
          freq_cnt_d   = edge_cnt_d;
          overflow_d   = ovf_d;
          freq_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        state_d    = cont ? S_GATE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      s_prev_q     <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      freq_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev_q     <= sig_s;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_q        <= ovf_d;
      freq_cnt_q   <= freq_cnt_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign freq_cnt   = freq_cnt_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;

endmodule
